// File: rtl/thermal_pkg.sv
// Shared constants and helpers for the thermal window sampler slice.
package thermal_pkg;

   // Fabric clock the heaters run from.
   localparam int unsigned CLK_HZ = 12_000_000;

   // Default measurement window: 60 s of fabric clock.
   localparam int unsigned DEFAULT_WINDOW_CYCLES = 60 * CLK_HZ;

   // Width of a counter that has to reach cycles-1; never narrower than 1 bit.
   function automatic int wcnt_width(input int unsigned cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/thermal_heater_channel.sv
// One heater channel: wide toggle register, registered tap of its MSB and a
// saturating activity counter. The parent sees the count including this
// edge's increment on total, and zeroes the live count through clear.
module thermal_heater_channel
   import thermal_pkg::*;
#(
   parameter int STAGES = 75,
   parameter int CNT_W  = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             heat_en,
   input  logic             clear,
   output logic [CNT_W-1:0] total
);

   logic [STAGES-1:0] toggle_p0;
   logic              tap_p1;
   logic [CNT_W-1:0]  live;

   // Increment by one unless already pinned at the all-ones ceiling.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic            inc);
      if (inc && (v != '1)) return v + CNT_W'(1);
      return v;
   endfunction

   // Stage 0: the whole register inverts each enabled cycle, drops to zero when disabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        toggle_p0 <= '0;
      else if (heat_en) toggle_p0 <= ~toggle_p0;
      else              toggle_p0 <= '0;
   end

   // Stage 1: register the far end of the toggle register as the activity tap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) tap_p1 <= 1'b0;
      else       tap_p1 <= toggle_p0[STAGES-1];
   end

   assign total = sat_inc(live, tap_p1);

   // Live count accumulates the tap and is zeroed at window end or restart.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      live <= '0;
      else if (clear) live <= '0;
      else            live <= total;
   end

endmodule

// File: rtl/thermal_window_sampler.sv
// Multi-channel thermal activity sampler. Counts heater activity per channel
// over a fixed window and offers a snapshot of all counts on valid/ready,
// flagging a sticky overrun when an unaccepted snapshot is overwritten.
// Build macro THERMAL_DECODE_EN adds a threshold decoder on channel 0
// (rx_bit / rx_bit_valid, parameter THRESH).
module thermal_window_sampler
   import thermal_pkg::*;
#(
   parameter int          NUM_CH        = 4,
   parameter int          STAGES        = 75,
   parameter int          CNT_W         = 20,
   parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
   parameter int          LED_CH        = 0
`ifdef THERMAL_DECODE_EN
   ,
   parameter int          THRESH        = 2**(CNT_W-1)
`endif
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       heat_en,
   input  logic                    restart,
   output logic [NUM_CH*CNT_W-1:0] sample_data,
   output logic                    sample_valid,
   input  logic                    sample_ready,
   output logic                    overrun,
   output logic [7:0]              leds
`ifdef THERMAL_DECODE_EN
   ,
   output logic                    rx_bit,
   output logic                    rx_bit_valid
`endif
);

   localparam int                WCNT_W    = wcnt_width(WINDOW_CYCLES);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW_CYCLES - 1);

   logic [WCNT_W-1:0]       wcnt;
   logic                    wrap;
   logic                    terminal;
   logic                    clear_live;
   logic [NUM_CH*CNT_W-1:0] totals;
   logic [NUM_CH*CNT_W-1:0] snap_next;
   logic                    valid_next;
   logic                    overrun_next;
   logic [7:0]              leds_next;

   // restart wins over a coincident window end: no snapshot is taken.
   assign wrap       = (wcnt == WCNT_LAST);
   assign terminal   = wrap && !restart;
   assign clear_live = wrap || restart;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      thermal_heater_channel #(
         .STAGES (STAGES),
         .CNT_W  (CNT_W)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .heat_en (heat_en[i]),
         .clear   (clear_live),
         .total   (totals[i*CNT_W +: CNT_W])
      );
   end

   // Window position: counts 0..WINDOW_CYCLES-1, back to 0 on wrap or restart.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           wcnt <= '0;
      else if (clear_live) wcnt <= '0;
      else                 wcnt <= wcnt + WCNT_W'(1);
   end

   // Snapshot, handshake and overrun next state; leds track the post-edge snapshot.
   always_comb begin
      snap_next    = sample_data;
      valid_next   = sample_valid;
      overrun_next = overrun;
      if (terminal) begin
         snap_next  = totals;
         valid_next = 1'b1;
         if (sample_valid && !sample_ready) overrun_next = 1'b1;
      end else if (sample_valid && sample_ready) begin
         valid_next = 1'b0;
      end
      leds_next = valid_next ? 8'(snap_next[LED_CH*CNT_W +: CNT_W]) : 8'h00;
   end

   // Output registers for the snapshot interface and the LED mirror.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_data  <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
         leds         <= 8'h00;
      end else begin
         sample_data  <= snap_next;
         sample_valid <= valid_next;
         overrun      <= overrun_next;
         leds         <= leds_next;
      end
   end

`ifdef THERMAL_DECODE_EN
   localparam int              TW       = CNT_W + 1;
   localparam logic [CNT_W:0]  THRESH_V = TW'(THRESH);

   // Channel 0 threshold decode, refreshed and pulsed with every snapshot load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_bit       <= 1'b0;
         rx_bit_valid <= 1'b0;
      end else begin
         rx_bit_valid <= terminal;
         if (terminal) rx_bit <= ({1'b0, totals[CNT_W-1:0]} >= THRESH_V);
      end
   end
`endif

endmodule
